// File: rtl/rpn_sequencer.sv
// rpn_sequencer: token-level controller for the calculator operand stack.
// Accepts number/operator tokens over valid/ready and drives the stack with
// single-cycle push/pop pulses. Operators fetch operands from the stack top,
// compute, and push the result back.
// Optional build macro RPN_SAT_ARITH_EN: ADD, SUB and NEG saturate as signed
// two's complement values instead of wrapping. MUL is unaffected.
module rpn_sequencer #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned SIZE_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tok_valid,
  output logic              tok_ready,
  input  logic              tok_is_op,
  input  logic [2:0]        tok_op,
  input  logic [WIDTH-1:0]  tok_num,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [WIDTH-1:0]  stk_data,
  input  logic [WIDTH-1:0]  stk_top,
  input  logic [SIZE_W-1:0] stk_size,
  input  logic              stk_error,
  input  logic              stk_vld,
  output logic [WIDTH-1:0]  result,
  output logic              res_valid,
  output logic              tok_done,
  output logic [1:0]        err
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_NEG = 3'b110;
  localparam logic [2:0] OP_CLR = 3'b111;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_UNDER = 2'b01;
  localparam logic [1:0] E_OVER  = 2'b10;
  localparam logic [1:0] E_FAULT = 2'b11;

`ifdef RPN_SAT_ARITH_EN
  localparam int unsigned     MSB  = WIDTH - 1;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP_B = 3'd1,
    S_POP_A = 3'd2,
    S_PUSH  = 3'd3,
    S_GAP   = 3'd4,
    S_WAIT  = 3'd5,
    S_EXEC  = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       pend_q, pend_d;
  logic             res_flag_q, res_flag_d;

  logic             push_d, pop_d, done_d, res_valid_d;
  logic [WIDTH-1:0] data_d, result_d;
  logic [1:0]       err_d;

  logic             accept;
  logic             stk_full;
  logic             stk_empty;
  logic             op_short;

  logic [WIDTH-1:0] sum_v, diff_v, neg_v, prod_v;
  logic [WIDTH-1:0] alu_c;

  // Token handshake and stack-occupancy decisions made at acceptance
  assign tok_ready = (state_q == S_IDLE) && stk_vld && !reset;
  assign accept    = tok_valid && tok_ready;
  assign stk_full  = (stk_size == SIZE_W'(DEPTH));
  assign stk_empty = (stk_size == '0);
  assign op_short  = (tok_op == OP_NEG) ? stk_empty : (stk_size < SIZE_W'(2));

  // Operator datapath: A is the deeper operand, B the former top
  always_comb begin : alu_comb
    sum_v  = a_q + b_q;
    diff_v = a_q - b_q;
    neg_v  = '0 - b_q;
    prod_v = a_q * b_q;
    alu_c  = '0;
    case (op_q)
      OP_ADD:  alu_c = sum_v;
      OP_SUB:  alu_c = diff_v;
      OP_MUL:  alu_c = prod_v;
      OP_AND:  alu_c = a_q & b_q;
      OP_OR:   alu_c = a_q | b_q;
      OP_XOR:  alu_c = a_q ^ b_q;
      OP_NEG:  alu_c = neg_v;
      default: alu_c = '0;
    endcase
`ifdef RPN_SAT_ARITH_EN
    if ((op_q == OP_ADD) && (a_q[MSB] == b_q[MSB]) && (sum_v[MSB] != a_q[MSB]))
      alu_c = a_q[MSB] ? SMIN : SMAX;
    if ((op_q == OP_SUB) && (a_q[MSB] != b_q[MSB]) && (diff_v[MSB] != a_q[MSB]))
      alu_c = a_q[MSB] ? SMIN : SMAX;
    if ((op_q == OP_NEG) && (b_q == SMIN))
      alu_c = SMAX;
`endif
  end

  // State register
  always_ff @(posedge clk) begin : state_reg
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: every command is pulse, GAP, then WAIT for the stack
  always_comb begin : next_state_comb
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!tok_is_op)              state_d = stk_full  ? S_DONE : S_PUSH;
          else if (tok_op == OP_CLR)   state_d = stk_empty ? S_DONE : S_POP_B;
          else                         state_d = op_short  ? S_DONE : S_POP_B;
        end
      end
      S_POP_B, S_POP_A, S_PUSH, S_EXEC: state_d = S_GAP;
      S_GAP:  state_d = S_WAIT;
      S_WAIT: begin
        if (stk_vld) begin
          if (stk_error)                             state_d = S_DONE;
          else if ((ret_q == S_POP_B) && stk_empty)  state_d = S_DONE;
          else                                       state_d = ret_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and operand-latch next values; outputs are registered below
  always_comb begin : output_comb
    push_d      = 1'b0;
    pop_d       = 1'b0;
    done_d      = 1'b0;
    res_valid_d = 1'b0;
    data_d      = stk_data;
    result_d    = result;
    err_d       = err;
    ret_d       = ret_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    pend_d      = pend_q;
    res_flag_d  = res_flag_q;

    if (accept) begin
      op_d       = tok_op;
      a_d        = '0;
      b_d        = stk_top;
      data_d     = tok_num;
      res_flag_d = 1'b0;
      if (!tok_is_op)
        pend_d = stk_full ? E_OVER : E_NONE;
      else if ((tok_op != OP_CLR) && op_short)
        pend_d = E_UNDER;
      else
        pend_d = E_NONE;
      if (!tok_is_op)                 ret_d = S_DONE;
      else if (tok_op == OP_CLR)      ret_d = S_POP_B;
      else if (tok_op == OP_NEG)      ret_d = S_EXEC;
      else                            ret_d = S_POP_A;
    end

    if ((state_q == S_WAIT) && stk_vld) begin
      if (stk_error) begin
        pend_d = E_FAULT;
      end else if (ret_q == S_POP_A) begin
        a_d   = stk_top;
        ret_d = S_EXEC;
      end else if (ret_q == S_EXEC) begin
        data_d     = alu_c;
        res_flag_d = 1'b1;
        ret_d      = S_DONE;
      end
    end

    push_d = (state_d == S_PUSH)  || (state_d == S_EXEC);
    pop_d  = (state_d == S_POP_B) || (state_d == S_POP_A);

    if (state_d == S_DONE) begin
      done_d = 1'b1;
      err_d  = pend_d;
      if (res_flag_d && (pend_d == E_NONE)) begin
        result_d    = stk_data;
        res_valid_d = 1'b1;
      end
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin : out_reg
    if (reset) begin
      stk_push   <= 1'b0;
      stk_pop    <= 1'b0;
      stk_data   <= '0;
      result     <= '0;
      res_valid  <= 1'b0;
      tok_done   <= 1'b0;
      err        <= E_NONE;
      ret_q      <= S_IDLE;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      pend_q     <= E_NONE;
      res_flag_q <= 1'b0;
    end else begin
      stk_push   <= push_d;
      stk_pop    <= pop_d;
      stk_data   <= data_d;
      result     <= result_d;
      res_valid  <= res_valid_d;
      tok_done   <= done_d;
      err        <= err_d;
      ret_q      <= ret_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      pend_q     <= pend_d;
      res_flag_q <= res_flag_d;
    end
  end

endmodule

// File: tb/tb_rpn_sequencer.sv
// tb_rpn_sequencer: directed and randomized token streams against a queue-based
// calculator model, with a one-busy-cycle behavioural stack attached.
module tb_rpn_sequencer;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned DEPTH  = 512;
  localparam int unsigned SIZE_W = 10;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_NEG = 3'b110;
  localparam logic [2:0] OP_CLR = 3'b111;

  logic              clk = 1'b0;
  logic              reset;
  logic              tok_valid, tok_ready, tok_is_op;
  logic [2:0]        tok_op;
  logic [WIDTH-1:0]  tok_num;
  logic              stk_push, stk_pop;
  logic [WIDTH-1:0]  stk_data, stk_top;
  logic [SIZE_W-1:0] stk_size;
  logic              stk_error, stk_vld;
  logic [WIDTH-1:0]  result;
  logic              res_valid, tok_done;
  logic [1:0]        err;

  rpn_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SIZE_W(SIZE_W)) dut (
    .clk(clk), .reset(reset),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op),
    .tok_op(tok_op), .tok_num(tok_num),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_data(stk_data),
    .stk_top(stk_top), .stk_size(stk_size), .stk_error(stk_error), .stk_vld(stk_vld),
    .result(result), .res_valid(res_valid), .tok_done(tok_done), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural stack: one busy cycle after each command
  logic [WIDTH-1:0] mem [DEPTH];
  int unsigned      sp;
  logic             fault_inj;

  always @(posedge clk) begin
    if (reset) begin
      sp        <= 0;
      stk_vld   <= 1'b1;
      stk_error <= 1'b0;
    end else begin
      if (stk_push) begin
        if (sp < DEPTH) begin mem[sp] <= stk_data; sp <= sp + 1; end
        else stk_error <= 1'b1;
      end else if (stk_pop) begin
        if (sp > 0) sp <= sp - 1;
        else stk_error <= 1'b1;
      end
      if (fault_inj && (stk_push || stk_pop)) stk_error <= 1'b1;
      stk_vld <= !(stk_push || stk_pop);
    end
  end

  assign stk_size = SIZE_W'(sp);
  assign stk_top  = (sp > 0) ? mem[sp-1] : '0;

  int both_cnt = 0;
  always @(negedge clk) if (stk_push && stk_pop) both_cnt++;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference calculator
  logic [WIDTH-1:0] ref_q[$];
  logic [WIDTH-1:0] last_res;
  int               exp_done, exp_push, exp_pop;
  bit               exp_rv;
  logic [1:0]       exp_err;
  logic [WIDTH-1:0] exp_pdata;

  function automatic logic [31:0] fit(input longint s);
`ifdef RPN_SAT_ARITH_EN
    longint maxv = 64'sd2147483647;
    longint minv = -64'sd2147483648;
    if (s > maxv) return 32'h7FFF_FFFF;
    if (s < minv) return 32'h8000_0000;
`endif
    return 32'(s);
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = 64'(a) * 64'(b);
    case (op)
      3'd0:    return fit(sa + sb);
      3'd1:    return fit(sa - sb);
      3'd2:    return p[31:0];
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a ^ b;
      3'd6:    return fit(-sb);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model(input logic is_op, input logic [2:0] op, input logic [31:0] num);
    int n;
    logic [31:0] a, b, r;
    n = ref_q.size();
    exp_push = 0; exp_pop = 0; exp_rv = 0; exp_err = 2'b00; exp_pdata = '0;
    if (!is_op) begin
      if (n == DEPTH) begin exp_err = 2'b10; exp_done = 1; end
      else begin ref_q.push_back(num); exp_push = 1; exp_pdata = num; exp_done = 4; end
    end else if (op == OP_CLR) begin
      exp_pop  = n;
      exp_done = (n == 0) ? 1 : 3 * n + 1;
      ref_q.delete();
    end else if (op == OP_NEG) begin
      if (n < 1) begin exp_err = 2'b01; exp_done = 1; end
      else begin
        b = ref_q.pop_back(); r = ref_alu(op, 32'h0, b); ref_q.push_back(r);
        exp_pop = 1; exp_push = 1; exp_pdata = r; exp_done = 7; exp_rv = 1; last_res = r;
      end
    end else begin
      if (n < 2) begin exp_err = 2'b01; exp_done = 1; end
      else begin
        b = ref_q.pop_back(); a = ref_q.pop_back(); r = ref_alu(op, a, b); ref_q.push_back(r);
        exp_pop = 2; exp_push = 1; exp_pdata = r; exp_done = 10; exp_rv = 1; last_res = r;
      end
    end
  endtask

  // Observations of one token
  int               obs_push, obs_pop, obs_done, obs_rv, obs_rv_cyc;
  logic [1:0]       obs_err;
  logic [WIDTH-1:0] obs_res, obs_pdata;

  task automatic run_tok(input logic is_op, input logic [2:0] op, input logic [31:0] num);
    int k;
    obs_push = 0; obs_pop = 0; obs_done = -1; obs_rv = 0; obs_rv_cyc = -1;
    obs_err = 'x; obs_res = 'x; obs_pdata = 'x;
    k = 0;
    @(negedge clk);
    while (!tok_ready && k < 50) begin @(negedge clk); k++; end
    check("ready_wait", 64'(tok_ready), 64'(1));
    tok_valid = 1'b1; tok_is_op = is_op; tok_op = op; tok_num = num;
    @(posedge clk);
    #1;
    tok_valid = 1'b0; tok_is_op = 1'($urandom); tok_op = 3'($urandom); tok_num = $urandom;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      if (stk_push) begin obs_push++; obs_pdata = stk_data; end
      if (stk_pop) obs_pop++;
      if (res_valid) begin obs_rv++; obs_rv_cyc = c; end
      if (tok_done) begin obs_done = c; obs_err = err; obs_res = result; break; end
    end
  endtask

  task automatic do_tok(input string tag, input logic is_op, input logic [2:0] op, input logic [31:0] num);
    model(is_op, op, num);
    run_tok(is_op, op, num);
    check({tag, "/done_cycle"}, 64'(obs_done), 64'(exp_done));
    check({tag, "/err"}, 64'(obs_err), 64'(exp_err));
    check({tag, "/push_cnt"}, 64'(obs_push), 64'(exp_push));
    check({tag, "/pop_cnt"}, 64'(obs_pop), 64'(exp_pop));
    if (exp_push != 0) check({tag, "/push_data"}, 64'(obs_pdata), 64'(exp_pdata));
    check({tag, "/res_valid_cnt"}, 64'(obs_rv), exp_rv ? 64'(1) : 64'(0));
    if (exp_rv) check({tag, "/res_valid_cycle"}, 64'(obs_rv_cyc), 64'(exp_done));
    check({tag, "/result"}, 64'(obs_res), 64'(last_res));
    check({tag, "/stk_size"}, 64'(stk_size), 64'(ref_q.size()));
    if (ref_q.size() > 0) check({tag, "/stk_top"}, 64'(stk_top), 64'(ref_q[$]));
    @(negedge clk);
    check({tag, "/err_hold"}, 64'(err), 64'(exp_err));
    check({tag, "/done_pulse"}, 64'(tok_done), 64'(0));
  endtask

  function automatic logic [31:0] rnd_num();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "/stk_push"}, 64'(stk_push), 64'(0));
    check({tag, "/stk_pop"}, 64'(stk_pop), 64'(0));
    check({tag, "/stk_data"}, 64'(stk_data), 64'(0));
    check({tag, "/result"}, 64'(result), 64'(0));
    check({tag, "/res_valid"}, 64'(res_valid), 64'(0));
    check({tag, "/tok_done"}, 64'(tok_done), 64'(0));
    check({tag, "/err"}, 64'(err), 64'(0));
    check({tag, "/tok_ready"}, 64'(tok_ready), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    logic [2:0] rop;
    reset = 1'b1; tok_valid = 1'b0; tok_is_op = 1'b0; tok_op = 3'b0; tok_num = '0;
    fault_inj = 1'b0; last_res = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check("reset/ready_after", 64'(tok_ready), 64'(1));

    // 5 3 SUB -> 2
    do_tok("push5", 1'b0, 3'b0, 32'd5);
    do_tok("push3", 1'b0, 3'b0, 32'd3);
    do_tok("sub", 1'b1, OP_SUB, 32'd0);
    check("sub/value", 64'(result), 64'(2));

    // Clear one entry, then underflow on empty stack
    do_tok("clr1", 1'b1, OP_CLR, 32'd0);
    do_tok("add_empty", 1'b1, OP_ADD, 32'd0);
    do_tok("neg_empty", 1'b1, OP_NEG, 32'd0);
    do_tok("clr_empty", 1'b1, OP_CLR, 32'd0);

    // 1 2 3 CLR -> three pops
    do_tok("p1", 1'b0, 3'b0, 32'd1);
    do_tok("p2", 1'b0, 3'b0, 32'd2);
    do_tok("p3", 1'b0, 3'b0, 32'd3);
    do_tok("clr3", 1'b1, OP_CLR, 32'd0);

    // Signed overflow corner on ADD, NEG of most-negative, MUL low bits
    do_tok("pmax", 1'b0, 3'b0, 32'h7FFF_FFFF);
    do_tok("pone", 1'b0, 3'b0, 32'h1);
    do_tok("add_ovf", 1'b1, OP_ADD, 32'd0);
`ifdef RPN_SAT_ARITH_EN
    check("add_ovf/value", 64'(result), 64'h7FFF_FFFF);
`else
    check("add_ovf/value", 64'(result), 64'h8000_0000);
`endif
    do_tok("pmin", 1'b0, 3'b0, 32'h8000_0000);
    do_tok("neg_min", 1'b1, OP_NEG, 32'd0);
    do_tok("pbig", 1'b0, 3'b0, 32'h0001_0003);
    do_tok("pbig2", 1'b0, 3'b0, 32'h0002_0005);
    do_tok("mul", 1'b1, OP_MUL, 32'd0);
    do_tok("clr_mix", 1'b1, OP_CLR, 32'd0);

    // Randomized token stream
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 99) < 55) do_tok("rnd_num", 1'b0, 3'b0, rnd_num());
      else begin
        rop = ($urandom_range(0, 19) == 0) ? OP_CLR : 3'($urandom_range(0, 6));
        do_tok("rnd_op", 1'b1, rop, 32'd0);
      end
    end

    // Fill to capacity, overflow push, then an ADD still works
    do_tok("clr_fill", 1'b1, OP_CLR, 32'd0);
    for (int i = 0; i < DEPTH; i++) do_tok("fill", 1'b0, 3'b0, rnd_num());
    do_tok("push_full", 1'b0, 3'b0, 32'd7);
    do_tok("add_full", 1'b1, OP_ADD, 32'd0);

    // Stack fault reported after WAIT
    fault_inj = 1'b1;
    run_tok(1'b0, 3'b0, 32'd9);
    fault_inj = 1'b0;
    check("fault/done_cycle", 64'(obs_done), 64'(4));
    check("fault/err", 64'(obs_err), 64'(3));
    check("fault/push_cnt", 64'(obs_push), 64'(1));
    check("fault/res_valid_cnt", 64'(obs_rv), 64'(0));

    // Reset pulse, then reset in the middle of an ADD at POP_A
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ref_q.delete(); last_res = '0;
    do_tok("rst_push4", 1'b0, 3'b0, 32'd4);
    do_tok("rst_push6", 1'b0, 3'b0, 32'd6);
    @(negedge clk);
    check("rst/ready", 64'(tok_ready), 64'(1));
    tok_valid = 1'b1; tok_is_op = 1'b1; tok_op = OP_ADD; tok_num = '0;
    @(posedge clk);
    #1;
    tok_valid = 1'b0;
    done_seen = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (tok_done) done_seen++;
    end
    check("rst/pop_a_pulse", 64'(stk_pop), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid");
    reset = 1'b0;
    ref_q.delete(); last_res = '0;
    @(negedge clk);
    check("rst/ready_after", 64'(tok_ready), 64'(1));
    check("rst/stk_size", 64'(stk_size), 64'(0));
    for (int c = 0; c < 12; c++) begin
      if (tok_done) done_seen++;
      @(negedge clk);
    end
    check("rst/no_tok_done", 64'(done_seen), 64'(0));
    do_tok("post_rst_push", 1'b0, 3'b0, 32'd8);
    do_tok("post_rst_neg", 1'b1, OP_NEG, 32'd0);

    check("push_pop_exclusive", 64'(both_cnt), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rpn_sequencer.md
Name: rpn_sequencer

Overview:
- Token-level controller for the calculator's operand stack (push/pop/top/size/error/out_vld interface, 32-bit entries, 512 deep).
- Accepts number and operator tokens over a valid/ready handshake and turns each one into push/pop command pulses.
- For operators it fetches operands from stack top, computes, and pushes the result back.
- Sits between the token decoder (keyboard/UART parser) and the stack; the result drives the display path.

Parameters:
- WIDTH, 32, operand/result width; must match the stack data width.
- DEPTH, 512, stack capacity; overflow threshold.
- SIZE_W, 10, width of the stack size input; must hold DEPTH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- tok_valid  in  1  token present
- tok_ready  out  1  token accepted on cycles where tok_valid && tok_ready
- tok_is_op  in  1  1 = operator token, 0 = number token
- tok_op  in  3  opcode: 000 ADD, 001 SUB (A-B), 010 MUL (low WIDTH bits), 011 AND, 100 OR, 101 XOR, 110 NEG (unary), 111 CLR
- tok_num  in  WIDTH  number to push
- stk_push  out  1  one-cycle push command
- stk_pop  out  1  one-cycle pop command
- stk_data  out  WIDTH  push data; valid while stk_push is high
- stk_top  in  WIDTH  current stack top
- stk_size  in  SIZE_W  current entry count
- stk_error  in  1  stack error flag
- stk_vld  in  1  stack idle; stk_top and stk_size valid
- result  out  WIDTH  last computed value
- res_valid  out  1  one-cycle pulse when result updates
- tok_done  out  1  one-cycle pulse at completion of every accepted token
- err  out  2  00 none, 01 underflow, 10 overflow, 11 stack fault; updated at tok_done, held until next tok_done

Behaviour:
- Reset: go to IDLE; all outputs 0; operand latches cleared. Reset mid-sequence abandons the token with no tok_done. The stack shares the same reset.
- Handshake: tok_ready = (state==IDLE) && stk_vld && !reset. Only one token in flight at a time.
- Command timing: stk_push/stk_pop are registered single-cycle pulses, never both high together.
- Each command sequence is: pulse cycle, then one GAP cycle, then WAIT. WAIT holds while stk_vld is 0 and samples stk_top/stk_size in the first cycle stk_vld is 1.
- States: IDLE, POP_B, POP_A, PUSH, GAP, WAIT, EXEC, DONE. A return-target register selects the state that follows WAIT.
- After each WAIT: if stk_error is 1, go to DONE with err=11.
- Acceptance cycle is numbered 0. All latencies below assume a stack with one busy cycle per command.
- Number token:
  - If stk_size==DEPTH: no command; err=10; tok_done in cycle 1.
  - Otherwise push tok_num in cycle 1; tok_done in cycle 4.
- Binary op (ADD..XOR):
  - If stk_size<2: no command; err=01; tok_done in cycle 1; stack unchanged.
  - Otherwise latch B=stk_top at acceptance, pop (cycle 1), then latch A=top after WAIT (cycle 3).
  - Pop (cycle 4), compute in EXEC, push result (cycle 7).
  - result/res_valid/tok_done in cycle 10; net stack size -1.
- NEG:
  - If stk_size<1: err=01.
  - Otherwise latch B, pop, push 0-B (two's complement, wraps; NEG of 0x80000000 = 0x80000000); done in cycle 7.
- CLR: pop repeatedly through GAP/WAIT until sampled stk_size==0; tok_done when empty; empty stack gives tok_done in cycle 1 with err=00.
- Arithmetic: ADD/SUB/MUL modulo 2^WIDTH. MUL keeps the low WIDTH bits of the unsigned product.
- A successful token sets err=00 at tok_done.
- tok_valid deasserted mid-sequence has no effect once the token is accepted.

Optional Feature:
- Macro RPN_SAT_ARITH_EN.
- Defined: ADD, SUB and NEG saturate as signed two's complement: overflow clamps to 0x7FFFFFFF, underflow to 0x80000000, NEG(0x80000000)=0x7FFFFFFF. MUL is unaffected. Latency unchanged.
- Undefined: wrap-around arithmetic as above.

Test Plan:
- Push 5, push 3, op SUB -> stack pops/pushes seen; result=2, res_valid in cycle 10 after op acceptance, stk_size=1, err=00.
- Empty stack, op ADD -> no stk_pop/stk_push pulses; err=01, tok_done in cycle 1; stack size stays 0.
- Fill to 512 entries, push 7 -> no stk_push; err=10; stk_size stays 512; then op ADD succeeds with err=00.
- Push 0x7FFFFFFF, push 1, ADD -> result=0x80000000; with RPN_SAT_ARITH_EN, result=0x7FFFFFFF.
- Push 1, 2, 3, op CLR -> exactly 3 stk_pop pulses; stk_size=0; tok_done with err=00.
- Push 4, push 6, assert reset during POP_A -> all outputs 0, state IDLE, no tok_done; tok_ready high 1 cycle after reset releases.
